// File: rtl/tile_pixel_fetch.sv
// Tile-map pixel source: five-stage pipeline turning display coordinates into RGB332 colours
// through an external tile-map RAM, an external font ROM and a small writable palette.
module tile_pixel_fetch #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned TILES_PER_ROW = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request,
  input  logic [9:0]  column,
  input  logic [9:0]  row,
  input  logic        bright,
  output logic [12:0] tile_addr,
  input  logic [7:0]  tile_data,
  output logic [8:0]  glyph_addr,
  input  logic [7:0]  glyph_data,
  input  logic        pal_we,
  input  logic [3:0]  pal_addr,
  input  logic [7:0]  pal_data,
  output logic [7:0]  color_out,
  output logic        color_valid
);

  localparam logic [9:0] LP_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] LP_V_ACTIVE = 10'(V_ACTIVE);

  logic        w_border;
  logic [5:0]  w_tile_row;
  logic [12:0] w_row_base;
  logic [12:0] w_tile_addr;
  logic        w_pix;
  logic [7:0]  w_color;

  logic [12:0] r_tile_addr;
  logic [8:0]  r_glyph_addr;
  logic [7:0]  r_color;
  logic        r_color_valid;
  logic [7:0]  r_pal [9];

  logic        r_v1, r_v2, r_v3, r_v4;
  logic [2:0]  r_col1, r_col2, r_col3, r_col4;
  logic [2:0]  r_row1, r_row2;
  logic        r_border1, r_border2, r_border3, r_border4;
  logic        r_bright1, r_bright2, r_bright3, r_bright4;
  logic [1:0]  r_pal3, r_pal4;

  assign w_border   = (column >= LP_H_ACTIVE) || (row >= LP_V_ACTIVE);
  assign w_tile_row = row[8:3];

  // The 80-tile stride reduces to two shifted adds; other strides fall back to a multiply.
  if (TILES_PER_ROW == 80) begin : g_shift
    assign w_row_base = {1'b0, w_tile_row, 6'b0} + {3'b0, w_tile_row, 4'b0};
  end else begin : g_mul
    assign w_row_base = 13'(32'(w_tile_row) * TILES_PER_ROW);
  end

  assign w_tile_addr = w_row_base + {6'b0, column[9:3]};
  assign w_pix       = glyph_data[3'd7 - r_col4];

  always_comb begin
    w_color = 8'h00;
    if (!r_bright4) begin
      w_color = 8'h00;
    end else if (r_border4) begin
      w_color = r_pal[8];
    end else if (w_pix) begin
      w_color = r_pal[{1'b0, r_pal4, 1'b0}];
    end else begin
      w_color = r_pal[{1'b0, r_pal4, 1'b1}];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tile_addr   <= '0;
      r_glyph_addr  <= '0;
      r_color       <= 8'h00;
      r_color_valid <= 1'b0;
      r_v1          <= 1'b0;
      r_v2          <= 1'b0;
      r_v3          <= 1'b0;
      r_v4          <= 1'b0;
      r_col1        <= '0;
      r_col2        <= '0;
      r_col3        <= '0;
      r_col4        <= '0;
      r_row1        <= '0;
      r_row2        <= '0;
      r_border1     <= 1'b0;
      r_border2     <= 1'b0;
      r_border3     <= 1'b0;
      r_border4     <= 1'b0;
      r_bright1     <= 1'b0;
      r_bright2     <= 1'b0;
      r_bright3     <= 1'b0;
      r_bright4     <= 1'b0;
      r_pal3        <= '0;
      r_pal4        <= '0;
      r_pal[0]      <= 8'hFF;
      r_pal[1]      <= 8'h00;
      r_pal[2]      <= 8'hE0;
      r_pal[3]      <= 8'h00;
      r_pal[4]      <= 8'h1C;
      r_pal[5]      <= 8'h00;
      r_pal[6]      <= 8'h03;
      r_pal[7]      <= 8'h00;
      r_pal[8]      <= 8'h00;
    end else begin
      // S1: register coordinates and issue the tile-map read
      r_v1 <= request;
      if (request) begin
        r_tile_addr <= w_border ? 13'd0 : w_tile_addr;
        r_col1      <= column[2:0];
        r_row1      <= row[2:0];
        r_border1   <= w_border;
        r_bright1   <= bright;
      end
      // S2: tile-map read in flight
      r_v2      <= r_v1;
      r_col2    <= r_col1;
      r_row2    <= r_row1;
      r_border2 <= r_border1;
      r_bright2 <= r_bright1;
      // S3: tile entry available, issue the font read
      r_v3      <= r_v2;
      if (r_v2) begin
        r_glyph_addr <= {tile_data[5:0], r_row2};
        r_pal3       <= tile_data[7:6];
      end
      r_col3    <= r_col2;
      r_border3 <= r_border2;
      r_bright3 <= r_bright2;
      // S4: font read in flight
      r_v4      <= r_v3;
      r_col4    <= r_col3;
      r_border4 <= r_border3;
      r_bright4 <= r_bright3;
      r_pal4    <= r_pal3;
      // S5: colour select against pre-edge palette contents
      r_color_valid <= r_v4;
      if (r_v4) begin
        r_color <= w_color;
      end
      if (pal_we && (pal_addr <= 4'd8)) begin
        r_pal[pal_addr] <= pal_data;
      end
    end
  end

  assign tile_addr   = r_tile_addr;
  assign glyph_addr  = r_glyph_addr;
  assign color_out   = r_color;
  assign color_valid = r_color_valid;

endmodule

// File: doc/tile_pixel_fetch.md
# tile_pixel_fetch

Tile-based pixel source between the VGA signal generator and the RGB output path. It takes the generator's pixel request and display coordinates and returns one RGB332 colour per request after a fixed pipeline latency. The colour comes from an 80x60 tile map, a 64-glyph 8x8 font ROM and a small writable palette. It replaces free-running pattern logic as the producer of next_color and drives the addresses of two external synchronous-read memories.

## Interface

Parameters:
- H_ACTIVE, 640, active pixels per line; columns at or above this are border.
- V_ACTIVE, 480, active lines; rows at or above this are border.
- TILES_PER_ROW, 80, tile-map row stride (H_ACTIVE/8).

Ports:
- clk  in  1  system clock, pixel-rate enable supplied via request
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high, sampled on rising clk
- request  in  1  generator asks for one pixel this cycle
- column  in  10  display column of requested pixel
- row  in  10  display row of requested pixel
- bright  in  1  pixel lies in visible region; low forces black
- tile_addr  out  13  tile-map RAM address (registered)
- tile_data  in  8  tile-map entry: [5:0] glyph index, [7:6] palette select
- glyph_addr  out  9  font ROM address {glyph[5:0], row[2:0]} (registered)
- glyph_data  in  8  font row; bit 7 = leftmost pixel
- pal_we  in  1  palette register write strobe
- pal_addr  in  4  0-7: palette p fg at 2p, bg at 2p+1; 8: border; 9-15 ignored
- pal_data  in  8  RGB332 value to write
- color_out  out  8  RGB332 pixel colour (registered)
- color_valid  out  1  color_out holds a requested pixel this cycle

## Operation

- Five-stage pipeline, one pixel per cycle sustained. No stall or backpressure. A valid bit and sideband (col[2:0], row[2:0], border, bright) travel with each pixel.
- S1 (register inputs): border = (column >= H_ACTIVE) || (row >= V_ACTIVE).
  - tile_addr <= border ? 0 : row[8:3]*TILES_PER_ROW + column[9:3].
  - Implement the multiply as (row<<6)+(row<<4); maximum address 4799.
- S2: tile_data is valid from the RAM. No registering is needed here beyond the sideband delay.
- S3: glyph_addr <= {tile_data[5:0], row[2:0]}. Palette select tile_data[7:6] is registered into the sideband.
- S4: glyph_data is valid.
- S5 (output register):
  - pix = glyph_data[7 - col[2:0]].
  - color_out <= !bright ? 8'h00 : border ? border_reg : pix ? fg[p] : bg[p].
  - color_valid <= stage valid.
- If request is low, no valid pixel enters the pipe. color_valid is low 5 cycles later and color_out holds its last value.
- Palette file: 9 x 8-bit registers, written on a clk edge when pal_we=1. Writes to pal_addr 9-15 have no effect.
- The S5 colour selection reads palette registers as they stand before the current edge. A write in the same cycle as a pixel's S5 uses the old value; the new value applies from the next pixel.
- Priority: bright low > border > glyph.

## Timing

- request/column/row sampled in cycle N.
  - tile_addr valid in cycle N+1.
  - tile_data valid in N+2.
  - glyph_addr valid in N+3.
  - glyph_data valid in N+4.
  - color_out/color_valid valid in N+5.
- Fixed latency is 5. The generator must issue coordinates 5 pixel slots ahead.
- External memories: the address is sampled on a rising edge and data is valid in the following cycle.
- Reset values:
  - color_out=8'h00, color_valid=0, tile_addr=0, glyph_addr=0, all pipeline valid bits 0.
  - fg0=FF bg0=00, fg1=E0 bg1=00, fg2=1C bg2=00, fg3=03 bg3=00, border=00.
- Reset mid-stream: every in-flight pixel is discarded. color_valid=0 in the cycle after the reset edge, and stays 0 until 5 cycles after the first request following reset deassertion.
- Reset and pal_we in the same cycle: reset wins.
- Column 639 is active and 640 is border. Row 479 is active and 480 is border. Column/row 1023 is border.

## Test plan

- Reset, then idle: every output equals its listed reset value. 20 cycles with request=0 give color_valid=0 throughout.
- Tile map entry 0 = 8'h40 (palette 1, glyph 0), glyph 0 row 0 = 8'h80, request (col 0, row 0, bright 1) then (col 1, row 0):
  - tile_addr=0 in N+1 and glyph_addr=0 in N+3.
  - color_out=E0 in N+5, then 00 (bg1) in N+6.
- Address math: request (col 639, row 479) -> tile_addr=4799. Request (col 8, row 8) -> tile_addr=81. Request (col 700, row 10) -> tile_addr=0 and color_out=border value.
- Write border=8'h55 then request col 640, bright 1 -> 55. Same request with bright 0 -> 00.
- pal_we to fg0=8'h12 in the same cycle a fg0 pixel is in S5 -> that pixel is FF and the next fg0 pixel is 12.
- Stream of 16 back-to-back requests, reset asserted at the 8th -> color_valid=0 from the next cycle. After restart, first valid pixel appears exactly 5 cycles after the first new request.
